frame_filter_writer: RTL and testbench

- Upstream stage of the VGA scan-out controller; fills the 200x150 frame buffer that the controller reads and upscales 2x.
- On a start pulse, reads a source image from a synchronous ROM, applies a selectable per-pixel filter, and writes each result to the frame-buffer write port in raster order.
- Pixel format is 12-bit {red[11:8], blue[7:4], green[3:0]}, the same packing the scan-out stage uses.

---
 rtl/frame_filter_writer.sv | 184 ++++++++++++++++++
 tb/tb_frame_filter_writer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_filter_writer.sv
// frame_filter_writer
//   Fills the scan-out frame buffer from a source image ROM. A start pulse
//   streams the whole image through a per-pixel filter. Results are written
//   to the frame-buffer port in raster order, two cycles after each ROM
//   address is presented.
//
// Ports
//   clk       system clock
//   rst       asynchronous, active-low reset (aborts any frame in progress)
//   start     one-cycle frame request, honoured only while idle
//   mode      filter select, latched at start:
//               0/5/6/7 pass, 1 invert, 2 gray, 3 threshold, 4 horizontal edge
//   busy      high while reading/flushing a frame (N+2 cycles)
//   done      one-cycle pulse in the cycle after the last write
//   src_addr  source ROM address; the ROM answers one cycle later on src_data
//   src_data  source pixel {red[11:8], blue[7:4], green[3:0]}
//   fb_addr   frame-buffer write address
//   fb_data   frame-buffer write data
//   fb_we     frame-buffer write enable
module frame_filter_writer #(
    parameter int IMG_W  = 200,
    parameter int IMG_H  = 150,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        mode,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [11:0]       src_data,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [11:0]       fb_data,
    output logic              fb_we
);

    localparam int N   = IMG_W * IMG_H;
    localparam int X_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
    localparam logic [X_W-1:0]    LAST_X    = X_W'(IMG_W - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t state_reg, state_next;

    logic [ADDR_W-1:0] src_addr_reg;
    logic [X_W-1:0]    x_reg;
    logic [2:0]        mode_reg;
    logic              flush_cnt_reg;

    // Stage 1: the address presented last cycle, whose data is on src_data now.
    logic              s1_valid_reg;
    logic [ADDR_W-1:0] s1_addr_reg;
    logic              s1_col0_reg;
    logic [3:0]        prev_gray_reg;

    logic [ADDR_W-1:0] fb_addr_reg;
    logic [11:0]       fb_data_reg;
    logic              fb_we_reg;

    logic [11:0]       filt_data;
    logic [11:0]       inv_data;
    logic [5:0]        gray_sum;
    logic [3:0]        gray;
    logic [3:0]        gray_prev;
    logic [3:0]        edge_val;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (src_addr_reg == LAST_ADDR) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                busy = 1'b1;
                // Two cycles: one for the ROM read, one for the write register.
                if (flush_cnt_reg) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------------------------------------------------------- filter
    // Gray weights green twice; the 6-bit sum peaks at 60, so >>2 fits 4 bits.
    assign gray_sum  = {2'b00, src_data[11:8]} + {2'b00, src_data[7:4]}
                     + {1'b0, src_data[3:0], 1'b0};
    assign gray      = 4'(gray_sum >> 2);
    // At the start of a row the pixel is compared with itself, so no edge
    // bleeds across the row boundary.
    assign gray_prev = s1_col0_reg ? gray : prev_gray_reg;
    assign edge_val  = (gray >= gray_prev) ? (gray - gray_prev) : (gray_prev - gray);

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_inv
            assign inv_data[gi*4 +: 4] = 4'hF - src_data[gi*4 +: 4];
        end
    endgenerate

    always_comb begin
        filt_data = src_data;
        case (mode_reg)
            3'd1:    filt_data = inv_data;
            3'd2:    filt_data = {gray, gray, gray};
            3'd3:    filt_data = gray[3] ? 12'hFFF : 12'h000;
            3'd4:    filt_data = {edge_val, edge_val, edge_val};
            default: filt_data = src_data;
        endcase
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_addr_reg  <= '0;
            x_reg         <= '0;
            mode_reg      <= '0;
            flush_cnt_reg <= 1'b0;
            s1_valid_reg  <= 1'b0;
            s1_addr_reg   <= '0;
            s1_col0_reg   <= 1'b0;
            prev_gray_reg <= '0;
            fb_addr_reg   <= '0;
            fb_data_reg   <= '0;
            fb_we_reg     <= 1'b0;
        end else begin
            if (state_reg == IDLE && start) begin
                src_addr_reg <= '0;
                x_reg        <= '0;
                mode_reg     <= mode;
            end else if (state_reg == RUN && src_addr_reg != LAST_ADDR) begin
                src_addr_reg <= src_addr_reg + 1'b1;
                x_reg        <= (x_reg == LAST_X) ? '0 : x_reg + 1'b1;
            end

            flush_cnt_reg <= (state_reg == FLUSH) ? ~flush_cnt_reg : 1'b0;

            // The column-0 flag travels with its address so the edge filter
            // knows a row boundary when the data arrives.
            s1_valid_reg <= (state_reg == RUN);
            s1_addr_reg  <= src_addr_reg;
            s1_col0_reg  <= (x_reg == '0);

            fb_we_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                fb_addr_reg   <= s1_addr_reg;
                fb_data_reg   <= filt_data;
                prev_gray_reg <= gray;
            end else if (state_reg == IDLE && start) begin
                prev_gray_reg <= '0;
            end
        end
    end

    assign src_addr = src_addr_reg;
    assign fb_addr  = fb_addr_reg;
    assign fb_data  = fb_data_reg;
    assign fb_we    = fb_we_reg;

endmodule

// File: tb/tb_frame_filter_writer.sv
module tb_frame_filter_writer;

    localparam int IMG_W  = 200;
    localparam int IMG_H  = 150;
    localparam int ADDR_W = 17;
    localparam int N      = IMG_W * IMG_H;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [2:0]        mode = 3'd0;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] src_addr;
    logic [11:0]       src_data = 12'h000;
    logic [ADDR_W-1:0] fb_addr;
    logic [11:0]       fb_data;
    logic              fb_we;

    int vectors     = 0;
    int miscompares = 0;

    logic [11:0] rom [N];
    logic [11:0] cap [N];

    // Observations from the most recent run_frame call.
    int n_writes, busy_cnt, done_cnt, first_we_k, last_we_k, done_k;
    int order_bad, busy_after, timed_out;

    frame_filter_writer #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .mode    (mode),
        .busy    (busy),
        .done    (done),
        .src_addr(src_addr),
        .src_data(src_data),
        .fb_addr (fb_addr),
        .fb_data (fb_data),
        .fb_we   (fb_we)
    );

    always #5 clk = ~clk;

    // Registered source ROM.
    always @(posedge clk) begin
        if (int'(src_addr) < N) src_data <= rom[src_addr];
        else                    src_data <= 12'h000;
    end

    // ------------------------------------------------------------ reference
    function automatic int gray_of(input logic [11:0] px);
        int r, b, g;
        r = int'(px[11:8]);
        b = int'(px[7:4]);
        g = int'(px[3:0]);
        return (r + 2 * g + b) / 4;
    endfunction

    function automatic logic [11:0] model_pixel(input int i, input int m);
        logic [11:0] px;
        int g, gp, e;
        px = rom[i];
        g  = gray_of(px);
        if (i % IMG_W == 0) gp = g;
        else                gp = gray_of(rom[i-1]);
        e = (g > gp) ? g - gp : gp - g;
        case (m)
            1:       return 12'hFFF - px;   // per-nibble 15-c, no borrows occur
            2:       return {3{4'(g)}};
            3:       return (g >= 8) ? 12'hFFF : 12'h000;
            4:       return {3{4'(e)}};
            default: return px;
        endcase
    endfunction

    // ------------------------------------------------------------ stimulus helpers
    // Starts a frame and records what the write port does. stop_writes > 0
    // returns once that many writes have been seen (frame still running).
    task automatic run_frame(input logic [2:0] m, input int stop_writes,
                             input bit perturb, input logic [2:0] alt_mode);
        int k, tail;
        bit done_seen;
        n_writes = 0; busy_cnt = 0; done_cnt = 0; first_we_k = -1;
        last_we_k = -1; done_k = -1; order_bad = 0; busy_after = 0; timed_out = 0;
        for (int i = 0; i < N; i++) cap[i] = 12'h000;
        @(posedge clk); #1;
        mode = m; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0; tail = 0; done_seen = 1'b0;
        while (1) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done_seen && busy) busy_after++;
            if (fb_we) begin
                if (first_we_k < 0) first_we_k = k;
                if (int'(fb_addr) != n_writes) order_bad++;
                if (int'(fb_addr) < N) cap[fb_addr] = fb_data;
                last_we_k = k;
                n_writes++;
            end
            if (done) begin
                done_cnt++;
                if (!done_seen) done_k = k;
                done_seen = 1'b1;
            end
            if (perturb) begin
                if (k == 5000) start = 1'b1;
                if (k == 5001) start = 1'b0;
                if (k == 7000) mode = alt_mode;
                if (done)           start = 1'b1;
                else if (done_seen) start = 1'b0;
            end
            if (done_seen) begin
                tail++;
                if (tail > 4) break;
            end
            if (stop_writes > 0 && n_writes >= stop_writes) break;
            k++;
            if (k > N + 200) begin
                timed_out = 1;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic do_abort();
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // ------------------------------------------------------------ tests
    task automatic test_reset();
        rst = 1'b0;
        #12;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%0b want=0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%0b want=0", done); end
        vectors++; if (fb_we !== 1'b0) begin miscompares++; $display("FAIL reset_fb_we got=%0b want=0", fb_we); end
        vectors++; if (src_addr !== '0) begin miscompares++; $display("FAIL reset_src_addr got=%0d want=0", src_addr); end
        vectors++; if (fb_addr !== '0) begin miscompares++; $display("FAIL reset_fb_addr got=%0d want=0", fb_addr); end
        vectors++; if (fb_data !== 12'h000) begin miscompares++; $display("FAIL reset_fb_data got=%h want=000", fb_data); end
        $display("reset: outputs sampled with rst low");
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy got=%0b want=0", busy); end
    endtask

    task automatic test_pass_through();
        for (int i = 0; i < N; i++) rom[i] = 12'(i);
        run_frame(3'd0, 0, 1'b0, 3'd0);
        $display("pass_through: writes=%0d busy_cycles=%0d done_pulses=%0d", n_writes, busy_cnt, done_cnt);
        vectors++; if (timed_out != 0) begin miscompares++; $display("FAIL pt_timeout got=%0d want=0", timed_out); end
        vectors++; if (n_writes != N) begin miscompares++; $display("FAIL pt_writes got=%0d want=%0d", n_writes, N); end
        vectors++; if (order_bad != 0) begin miscompares++; $display("FAIL pt_order got=%0d want=0", order_bad); end
        vectors++; if (first_we_k != 2) begin miscompares++; $display("FAIL pt_latency got=%0d want=2", first_we_k); end
        vectors++; if (busy_cnt != N + 2) begin miscompares++; $display("FAIL pt_busy got=%0d want=%0d", busy_cnt, N + 2); end
        vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL pt_done_count got=%0d want=1", done_cnt); end
        vectors++; if (done_k != N + 2) begin miscompares++; $display("FAIL pt_done_time got=%0d want=%0d", done_k, N + 2); end
        vectors++; if (last_we_k != N + 1) begin miscompares++; $display("FAIL pt_last_write got=%0d want=%0d", last_we_k, N + 1); end
        vectors++; if (int'(fb_addr) != N - 1) begin miscompares++; $display("FAIL pt_hold_addr got=%0d want=%0d", fb_addr, N - 1); end
        vectors++; if (fb_data !== 12'(N - 1)) begin miscompares++; $display("FAIL pt_hold_data got=%h want=%h", fb_data, 12'(N - 1)); end
        for (int i = 0; i < N; i++) begin
            vectors++;
            if (cap[i] !== 12'(i)) begin
                miscompares++;
                $display("FAIL pt_data addr=%0d got=%h want=%h", i, cap[i], 12'(i));
            end
        end
    endtask

    task automatic test_filters();
        for (int m = 1; m < 8; m++) begin
            for (int i = 0; i < 512; i++) rom[i] = 12'($urandom);
            rom[0] = 12'h333; rom[1] = 12'hAAA; rom[2] = 12'h444;   // grays 3,10,4
            rom[10] = 12'h3A5; rom[11] = 12'h000;
            rom[12] = 12'h84C; rom[13] = 12'h777;
            rom[199] = 12'h000; rom[200] = 12'hCCC;                  // gray 0 then 12
            run_frame(3'(m), 410, 1'b0, 3'd0);
            $display("filters: mode=%0d writes=%0d", m, n_writes);
            vectors++; if (first_we_k != 2) begin miscompares++; $display("FAIL flt_latency mode=%0d got=%0d want=2", m, first_we_k); end
            vectors++; if (order_bad != 0) begin miscompares++; $display("FAIL flt_order mode=%0d got=%0d want=0", m, order_bad); end
            for (int i = 0; i < 410; i++) begin
                vectors++;
                if (cap[i] !== model_pixel(i, m)) begin
                    miscompares++;
                    $display("FAIL flt_data mode=%0d addr=%0d got=%h want=%h", m, i, cap[i], model_pixel(i, m));
                end
            end
            case (m)
                1: begin
                    vectors++; if (cap[10] !== 12'hC5A) begin miscompares++; $display("FAIL inv_3a5 got=%h want=c5a", cap[10]); end
                    vectors++; if (cap[11] !== 12'hFFF) begin miscompares++; $display("FAIL inv_000 got=%h want=fff", cap[11]); end
                end
                2: begin
                    vectors++; if (cap[12] !== 12'h999) begin miscompares++; $display("FAIL gray_84c got=%h want=999", cap[12]); end
                end
                3: begin
                    vectors++; if (cap[12] !== 12'hFFF) begin miscompares++; $display("FAIL thr_84c got=%h want=fff", cap[12]); end
                    vectors++; if (cap[13] !== 12'h000) begin miscompares++; $display("FAIL thr_777 got=%h want=000", cap[13]); end
                end
                4: begin
                    vectors++; if (cap[0] !== 12'h000) begin miscompares++; $display("FAIL edge_x0 got=%h want=000", cap[0]); end
                    vectors++; if (cap[1] !== 12'h777) begin miscompares++; $display("FAIL edge_x1 got=%h want=777", cap[1]); end
                    vectors++; if (cap[2] !== 12'h666) begin miscompares++; $display("FAIL edge_x2 got=%h want=666", cap[2]); end
                    vectors++; if (cap[200] !== 12'h000) begin miscompares++; $display("FAIL edge_row1 got=%h want=000", cap[200]); end
                end
                default: begin
                    vectors++; if (cap[10] !== 12'h3A5) begin miscompares++; $display("FAIL pass_mode%0d got=%h want=3a5", m, cap[10]); end
                end
            endcase
            do_abort();
        end
    endtask

    task automatic test_handshake();
        logic [2:0] m;
        for (int i = 0; i < N; i++) rom[i] = 12'($urandom);
        m = 3'($urandom_range(1, 4));
        run_frame(m, 0, 1'b1, 3'd0);
        $display("handshake: mode=%0d writes=%0d busy_cycles=%0d done_pulses=%0d", m, n_writes, busy_cnt, done_cnt);
        vectors++; if (timed_out != 0) begin miscompares++; $display("FAIL hs_timeout got=%0d want=0", timed_out); end
        vectors++; if (n_writes != N) begin miscompares++; $display("FAIL hs_writes got=%0d want=%0d", n_writes, N); end
        vectors++; if (busy_cnt != N + 2) begin miscompares++; $display("FAIL hs_busy got=%0d want=%0d", busy_cnt, N + 2); end
        vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL hs_done_count got=%0d want=1", done_cnt); end
        vectors++; if (busy_after != 0) begin miscompares++; $display("FAIL hs_restart_at_done got=%0d want=0", busy_after); end
        vectors++; if (order_bad != 0) begin miscompares++; $display("FAIL hs_order got=%0d want=0", order_bad); end
        for (int i = 0; i < N; i++) begin
            vectors++;
            if (cap[i] !== model_pixel(i, int'(m))) begin
                miscompares++;
                $display("FAIL hs_data addr=%0d got=%h want=%h", i, cap[i], model_pixel(i, int'(m)));
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [2:0] m;
        int stray;
        for (int i = 0; i < N; i++) rom[i] = 12'($urandom);
        m = 3'($urandom_range(0, 7));
        run_frame(m, 1000, 1'b0, 3'd0);
        #2 rst = 1'b0;
        #1;
        $display("reset_abort: rst asserted after %0d writes, mode=%0d", n_writes, m);
        vectors++; if (fb_we !== 1'b0) begin miscompares++; $display("FAIL abort_fb_we got=%0b want=0", fb_we); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy got=%0b want=0", busy); end
        vectors++; if (src_addr !== '0) begin miscompares++; $display("FAIL abort_src_addr got=%0d want=0", src_addr); end
        vectors++; if (fb_addr !== '0) begin miscompares++; $display("FAIL abort_fb_addr got=%0d want=0", fb_addr); end
        for (int i = 0; i < 1000; i++) begin
            vectors++;
            if (cap[i] !== model_pixel(i, int'(m))) begin
                miscompares++;
                $display("FAIL abort_data addr=%0d got=%h want=%h", i, cap[i], model_pixel(i, int'(m)));
            end
        end
        stray = 0;
        repeat (4) begin
            @(negedge clk);
            if (fb_we || done || busy) stray++;
        end
        rst = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (fb_we || done || busy) stray++;
        end
        vectors++; if (stray != 0) begin miscompares++; $display("FAIL abort_stray got=%0d want=0", stray); end

        m = 3'($urandom_range(0, 7));
        run_frame(m, 300, 1'b0, 3'd0);
        $display("reset_abort: restart mode=%0d writes=%0d", m, n_writes);
        vectors++; if (first_we_k != 2) begin miscompares++; $display("FAIL restart_latency got=%0d want=2", first_we_k); end
        vectors++; if (order_bad != 0) begin miscompares++; $display("FAIL restart_order got=%0d want=0", order_bad); end
        vectors++; if (n_writes != 300) begin miscompares++; $display("FAIL restart_writes got=%0d want=300", n_writes); end
        for (int i = 0; i < 300; i++) begin
            vectors++;
            if (cap[i] !== model_pixel(i, int'(m))) begin
                miscompares++;
                $display("FAIL restart_data addr=%0d got=%h want=%h", i, cap[i], model_pixel(i, int'(m)));
            end
        end
        do_abort();
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_filters();
        test_handshake();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
